vga_write_port: RTL and testbench

// - VGA-side responder for the bridge's VGA write socket: accepts 4-phase write handshakes (addr/data/strobe), stores

---
 rtl/vga_write_port_pkg.sv | 26 ++
 rtl/vga_text_ram.sv | 39 +++
 rtl/vga_write_port.sv | 121 ++++++++++++
 tb/tb_vga_write_port.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_write_port_pkg.sv
// Shared constants and FSM state encoding for the VGA text-buffer write port.
// Geometry defaults describe an 80x25 text screen with 16-bit cells.
// Cell layout: [7:0] character code, [15:8] attribute.
package vga_write_port_pkg;

  localparam int VGA_COLS   = 80;
  localparam int VGA_ROWS   = 25;
  localparam int VGA_CELL_W = 16;
  localparam int VGA_ADDR_W = 32;
  localparam int VGA_DATA_W = 32;
  localparam int VGA_CNT_W  = 16;

  // Write-handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_DROP = 2'd3
  } wp_state_e;

  // Address width needed to index a buffer of the given cell count.
  function automatic int cell_aw(input int cells);
    return $clog2(cells);
  endfunction

endpackage

// File: rtl/vga_text_ram.sv
// Single-port text RAM: synchronous write, registered read.
// Read data appears one cycle after a read-enabled cycle and holds otherwise.
// A write cycle never reads; the caller arbitrates the single port.
module vga_text_ram #(
  parameter int DEPTH = 2000,
  parameter int AW    = 11,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  // Cell storage: contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: only the output latch is reset, and it holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_write_port.sv
// VGA-side responder for 4-phase bridge writes into the text RAM.
// Ack rises 3 cycles after vga_wr with no scan conflict, +1 per scan_en cycle in PEND.
// Scanout owns the RAM port whenever scan_en is high; bridge writes wait in PEND.
module vga_write_port
  import vga_write_port_pkg::*;
#(
  parameter int COLS   = VGA_COLS,
  parameter int ROWS   = VGA_ROWS,
  parameter int CELL_W = VGA_CELL_W,
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        vga_addr,
  input  logic [DATA_W-1:0]        vga_data,
  input  logic                     vga_wr,
  output logic                     vga_ack,
  output logic                     vga_err,
  input  logic                     scan_en,
  input  logic [cell_aw(COLS*ROWS)-1:0] scan_addr,
  output logic [CELL_W-1:0]        scan_data,
  output logic [VGA_CNT_W-1:0]     wr_count
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = cell_aw(CELLS);

  wp_state_e            state_q;
  logic [AW-1:0]        wr_addr_q;
  logic [CELL_W-1:0]    wr_cell_q;
  logic                 ack_q;
  logic                 err_q;
  logic [VGA_CNT_W-1:0] wr_count_q;
  logic [VGA_CNT_W-1:0] wr_count_d;

  logic                 addr_ok;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;

  // Only the low CELL_W data bits are stored; the rest is deliberately dropped.
  logic unused_data_hi;
  assign unused_data_hi = ^vga_data[DATA_W-1:CELL_W];

  // Range check over the full bus address, so any high bit set is out of range.
  always_comb begin
    addr_ok = (vga_addr < ADDR_W'(CELLS));
  end

  // Port arbitration: scanout always wins; a pending write commits on a free cycle.
  always_comb begin
    ram_we     = (state_q == ST_PEND) && !scan_en;
    ram_addr   = scan_en ? scan_addr : wr_addr_q;
    wr_count_d = wr_count_q + VGA_CNT_W'(1);
  end

  // Handshake FSM with registered ack/err and the successful-write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      wr_cell_q  <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vga_wr) begin
            wr_addr_q <= vga_addr[AW-1:0];
            wr_cell_q <= vga_data[CELL_W-1:0];
            if (!addr_ok) begin
              err_q   <= 1'b1;
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (!scan_en) begin
            wr_count_q <= wr_count_d;
            state_q    <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q   <= 1'b1;
          state_q <= ST_DROP;
        end
        ST_DROP: begin
          // A requester that already dropped wr sees a one-cycle ack pulse.
          if (!vga_wr) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  vga_text_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (CELL_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .re_i    (scan_en),
    .addr_i  (ram_addr),
    .wdata_i (wr_cell_q),
    .rdata_o (scan_data)
  );

  assign vga_ack  = ack_q;
  assign vga_err  = err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_vga_write_port.sv
// Directed bench for vga_write_port: handshake latency, range errors, scan
// arbitration, held/early-dropped requests, mid-handshake reset, counter wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vga_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] vga_addr;
  logic [31:0] vga_data;
  logic        vga_wr;
  logic        vga_ack;
  logic        vga_err;
  logic        scan_en;
  logic [10:0] scan_addr;
  logic [15:0] scan_data;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_write_port dut (
    .clk       (clk),
    .rst       (rst),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .vga_wr    (vga_wr),
    .vga_ack   (vga_ack),
    .vga_err   (vga_err),
    .scan_en   (scan_en),
    .scan_addr (scan_addr),
    .scan_data (scan_data),
    .wr_count  (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full 4-phase write: raise wr, wait (bounded) for ack, drop wr, confirm ack clears.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err);
    vga_addr = a;
    vga_data = d;
    vga_wr   = 1'b1;
    lat      = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vga_ack && lat < 50);
    err      = vga_err;
    vga_wr   = 1'b0;
    vga_addr = $urandom;
    vga_data = $urandom;
    @(negedge clk);
    chk("ack_clear", {31'd0, vga_ack}, 32'd0);
    chk("err_clear", {31'd0, vga_err}, 32'd0);
  endtask

  // One-cycle scanout read; result is the registered RAM output.
  task automatic rd(input logic [10:0] a, output logic [15:0] q);
    scan_en   = 1'b1;
    scan_addr = a;
    @(negedge clk);
    scan_en   = 1'b0;
    q         = scan_data;
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [15:0] q;
    logic        held_ok;
    logic [15:0] exp_cnt;

    rst = 1'b1; vga_addr = '0; vga_data = '0; vga_wr = 1'b0;
    scan_en = 1'b0; scan_addr = '0;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("rst_ack",   {31'd0, vga_ack}, 32'd0);
    chk("rst_err",   {31'd0, vga_err}, 32'd0);
    chk("rst_scan",  {16'd0, scan_data}, 32'd0);
    chk("rst_count", {16'd0, wr_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Seed the last cell so the out-of-range write can be shown harmless.
    do_write(32'd1999, 32'h0000_5A5A, lat, e); exp_cnt++;
    rd(11'd1999, q);
    chk("seed_1999", {16'd0, q}, 32'h5A5A);

    // Basic write: 3-cycle ack latency, no error, readback.
    do_write(32'd1, 32'h0000_012B, lat, e); exp_cnt++;
    chk("w1_latency", lat, 32'd3);
    chk("w1_err", {31'd0, e}, 32'd0);
    chk("w1_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    rd(11'd1, q);
    chk("w1_read", {16'd0, q}, 32'h012B);

    // Address 2000 is one past the end: err, no write, no count.
    do_write(32'd2000, 32'h0000_FFFF, lat, e);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_latency", lat, 32'd2);
    chk("oor_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    rd(11'd1999, q);
    chk("oor_1999", {16'd0, q}, 32'h5A5A);

    // High address bit set with in-range low bits must still be rejected.
    do_write(32'h0001_0005, 32'h0000_DEAD, lat, e);
    chk("oor_hi_err", {31'd0, e}, 32'd1);
    chk("oor_hi_count", {16'd0, wr_count}, {16'd0, exp_cnt});

    // Scan conflict: four scan cycles while PEND push ack from +3 to +7.
    vga_addr = 32'd5; vga_data = 32'hCAFE_0505; vga_wr = 1'b1;
    @(negedge clk);
    lat = 1;
    scan_en = 1'b1; scan_addr = 11'd1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    chk("conf_stall_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    chk("conf_scan_data", {16'd0, scan_data}, 32'h012B);
    scan_en = 1'b0;
    while (!vga_ack && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp_cnt++;
    chk("conf_latency", lat, 32'd7);
    chk("conf_err", {31'd0, vga_err}, 32'd0);
    vga_wr = 1'b0;
    @(negedge clk);
    chk("conf_ack_clear", {31'd0, vga_ack}, 32'd0);
    chk("conf_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    rd(11'd5, q);
    chk("conf_read", {16'd0, q}, 32'h0505);
    // scan_data holds when scan_en is low, even with a different address.
    scan_addr = 11'd1;
    @(negedge clk);
    chk("scan_hold", {16'd0, scan_data}, 32'h0505);

    // Hold wr 10 cycles past ack with changing bus inputs: ack stays, one write.
    vga_addr = 32'd10; vga_data = 32'h0000_ABCD; vga_wr = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!vga_ack && lat < 50);
    exp_cnt++;
    held_ok = 1'b1;
    vga_addr = 32'd11; vga_data = 32'h0000_FFFF;
    repeat (10) begin
      @(negedge clk);
      if (vga_ack !== 1'b1) held_ok = 1'b0;
    end
    chk("hold_ack", {31'd0, held_ok}, 32'd1);
    chk("hold_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    vga_wr = 1'b0;
    @(negedge clk);
    chk("hold_ack_drop", {31'd0, vga_ack}, 32'd0);
    rd(11'd10, q);
    chk("hold_read", {16'd0, q}, 32'hABCD);

    // Early drop of wr: write still completes and ack pulses for one cycle.
    vga_addr = 32'd11; vga_data = 32'h0000_1234; vga_wr = 1'b1;
    @(negedge clk);
    vga_wr = 1'b0;
    @(negedge clk);
    chk("early_no_ack", {31'd0, vga_ack}, 32'd0);
    @(negedge clk);
    chk("early_ack_pulse", {31'd0, vga_ack}, 32'd1);
    @(negedge clk);
    chk("early_ack_gone", {31'd0, vga_ack}, 32'd0);
    exp_cnt++;
    chk("early_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    rd(11'd11, q);
    chk("early_read", {16'd0, q}, 32'h1234);

    // Reset while PEND: pending write lost, committed one persists, counter cleared.
    do_write(32'd20, 32'h0000_1111, lat, e); exp_cnt++;
    rd(11'd20, q);
    vga_addr = 32'd20; vga_data = 32'h0000_2222; vga_wr = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstp_ack", {31'd0, vga_ack}, 32'd0);
    chk("rstp_count", {16'd0, wr_count}, 32'd0);
    chk("rstp_scan", {16'd0, scan_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0; vga_wr = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    rd(11'd20, q);
    chk("rstp_cell", {16'd0, q}, 32'h1111);
    do_write(32'd20, 32'h0000_3333, lat, e); exp_cnt++;
    chk("rstp_next_latency", lat, 32'd3);
    chk("rstp_next_count", {16'd0, wr_count}, {16'd0, exp_cnt});
    rd(11'd20, q);
    chk("rstp_next_read", {16'd0, q}, 32'h3333);

    // Counter wrap from 16'hFFFF to 0 on the next successful write.
    force dut.wr_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("wrap_preload", {16'd0, wr_count}, 32'hFFFF);
    do_write(32'd30, 32'h0000_0030, lat, e);
    chk("wrap_count", {16'd0, wr_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
